// File: rtl/rv_data_ram.sv
// rv_data_ram: doubleword data RAM serving core load/store plus a host valid/ready port, zero-filled after reset
// Ports:
//   i_clock, i_reset          single clock, synchronous active-high reset
//   i_ram_load/i_ram_store    core access request this cycle
//   i_ram_address             doubleword address (byte address bits [63:3])
//   i_ram_store_value         merged doubleword to store
//   o_ram_load_value          combinational read at i_ram_address (0 when not served)
//   o_busy                    zero-fill in progress (also high while in reset)
//   o_fault                   core access out of range or during busy
//   i_host_valid/o_host_ready host handshake; core access has priority
//   i_host_write              1 = write, 0 = read
//   i_host_address/i_host_wdata host word index and write data
//   o_host_rvalid/o_host_rdata host read response one cycle after acceptance
module rv_data_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_ram_load,
    input  logic                  i_ram_store,
    input  logic [60:0]           i_ram_address,
    input  logic [63:0]           i_ram_store_value,
    output logic [63:0]           o_ram_load_value,
    output logic                  o_busy,
    output logic                  o_fault,
    input  logic                  i_host_valid,
    output logic                  o_host_ready,
    input  logic                  i_host_write,
    input  logic [DEPTH_LOG2-1:0] i_host_address,
    input  logic [63:0]           i_host_wdata,
    output logic                  o_host_rvalid,
    output logic [63:0]           o_host_rdata
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    typedef enum logic {CLEAR, RUN} state_t;
    state_t                r_state, w_state_next;
    logic [DEPTH_LOG2-1:0] r_clear_idx, w_clear_idx_next;
    logic [63:0]           r_mem [DEPTH];
    logic                  w_busy, w_access, w_in_range, w_store_ok, w_host_wr, w_host_rd, w_we;
    logic [DEPTH_LOG2-1:0] w_core_idx, w_waddr;
    logic [63:0]           w_wdata;
    assign w_busy      = i_reset || (r_state == CLEAR);
    assign w_access    = i_ram_load || i_ram_store;
    // no aliasing: every address bit above the array index must be zero
    assign w_in_range  = (i_ram_address[60:DEPTH_LOG2] == '0);
    assign w_core_idx  = i_ram_address[DEPTH_LOG2-1:0];
    assign w_store_ok  = i_ram_store && w_in_range && !w_busy;
    assign o_host_ready = !w_busy && !w_access;
    assign w_host_wr   = i_host_valid && o_host_ready && i_host_write;
    assign w_host_rd   = i_host_valid && o_host_ready && !i_host_write;
    assign o_busy      = w_busy;
    assign o_fault     = w_access && (!w_in_range || w_busy);
    // read also serves stores so the core can merge sub-doubleword writes
    assign o_ram_load_value = (w_access && w_in_range && !w_busy) ? r_mem[w_core_idx] : 64'h0;
    always_comb begin
        w_state_next     = r_state;
        w_clear_idx_next = r_clear_idx;
        if (r_state == CLEAR) begin
            w_clear_idx_next = r_clear_idx + DEPTH_LOG2'(1);
            w_state_next     = (&r_clear_idx) ? RUN : CLEAR;
        end
    end
    // core and host writes are mutually exclusive, clear writes only happen while both are blocked
    always_comb begin
        w_we    = !i_reset && ((r_state == CLEAR) || w_store_ok || w_host_wr);
        w_waddr = (r_state == CLEAR) ? r_clear_idx : (w_store_ok ? w_core_idx : i_host_address);
        w_wdata = (r_state == CLEAR) ? 64'h0 : (w_store_ok ? i_ram_store_value : i_host_wdata);
    end
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= CLEAR;
            r_clear_idx   <= '0;
            o_host_rvalid <= 1'b0;
            o_host_rdata  <= 64'h0;
        end else begin
            r_state       <= w_state_next;
            r_clear_idx   <= w_clear_idx_next;
            o_host_rvalid <= w_host_rd;
            if (w_host_rd) o_host_rdata <= r_mem[i_host_address];
        end
    end
    always_ff @(posedge i_clock) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end
endmodule

// File: doc/rv_data_ram.md
Name: rv_data_ram

Overview:
- Data-memory responder on the other end of the CPU's doubleword RAM interface.
- Answers load/store requests from the core: combinational read, store committed on the clock edge.
- Zero-fills its array after every reset.
- Exposes a host port with valid/ready handshake so the testbench or loader can preload and inspect data while the core is idle.

Parameters:
DEPTH_LOG2, 10, log2 of number of 64-bit words; DEPTH = 2**DEPTH_LOG2

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
ram_load  input  1  core load request this cycle
ram_store  input  1  core store request this cycle
ram_address  input  61  doubleword address, bits [63:3] of byte address
ram_store_value  input  64  fully merged doubleword to write
ram_load_value  output  64  doubleword read at ram_address
busy  output  1  zero-fill in progress
fault  output  1  core access invalid this cycle
host_valid  input  1  host request valid
host_ready  output  1  host request accepted when valid && ready
host_write  input  1  1 = write, 0 = read
host_address  input  DEPTH_LOG2  host word index
host_wdata  input  64  host write data
host_rvalid  output  1  host read data valid, one-cycle pulse
host_rdata  output  64  host read data

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- States: CLEAR, RUN.
  - Reset forces CLEAR, clear_index=0, host_rvalid=0, host_rdata=0.
- CLEAR:
  - Each cycle with reset low writes mem[clear_index]=0 and increments clear_index.
  - After writing index DEPTH-1, go to RUN. busy drops on the cycle after the last write.
  - busy is high during reset and for exactly DEPTH cycles after reset deasserts.
- Reset mid-CLEAR or mid-RUN:
  - Restarts CLEAR at index 0.
  - Any pending host_rvalid is cancelled.
- in_range = ram_address < DEPTH, i.e. upper 61-DEPTH_LOG2 bits are zero. No aliasing.
- Core access (ram_load|ram_store):
  - ram_load_value = mem[ram_address] combinationally when (ram_load|ram_store) && in_range && !busy; otherwise 64'h0.
  - The read is required on stores too, because the core merges sub-doubleword stores from it.
  - Store commits mem[ram_address]=ram_store_value at the edge when ram_store && in_range && !busy.
  - The same-cycle ram_load_value shows the pre-store value.
- fault is combinational: (ram_load|ram_store) && (!in_range || busy).
  - Faulting stores are dropped.
  - fault is 0 when there is no access.
- Host port:
  - host_ready = !busy && !ram_load && !ram_store. The core always has priority; reset value 0.
  - A transfer occurs at an edge where host_valid && host_ready.
  - Write transfer: mem[host_address]=host_wdata.
  - Read transfer: next cycle host_rvalid=1 and host_rdata=mem[host_address] as sampled at the accepting edge. host_rvalid returns to 0 the following cycle unless another read is accepted.
  - host_rdata holds its value after host_rvalid falls.
  - Back-to-back accepted reads give host_rvalid high on consecutive cycles.
  - host_address is DEPTH_LOG2 wide, so it is always in range.
- Core and host transfers never coincide, so there is at most one write per edge (plus the clear write, which only happens in CLEAR, when neither is allowed).
- No other latency: core path is 0-cycle read / 1-edge write; host read is 1 cycle.

Test Plan:
- Run with DEPTH_LOG2=4.
- Reset count: hold reset 3 cycles, release -> busy=1 for exactly 16 cycles then 0. ram_load at address 2 during busy -> fault=1, ram_load_value=0. host_ready=0 throughout.
- Store/load: in RUN, ram_store address 3 value 64'h0123456789abcdef -> same cycle ram_load_value=0, fault=0. Next cycle ram_load address 3 -> 64'h0123456789abcdef.
- Out-of-range: ram_store address 16 value 64'hffff -> fault=1. ram_load address 0 next cycle -> 0, showing no aliasing. ram_load address 61'h1_0000_0003 -> fault=1, value 0.
- Host handshake:
  - Core idle, host write word 5 = 64'hdeadbeef -> host_ready=1, accepted.
  - Host read word 5 -> host_rvalid=1 next cycle with host_rdata=64'hdeadbeef, then 0.
  - host_valid held while ram_load=1 -> host_ready=0, no transfer until ram_load drops.
  - Core ram_load address 5 -> 64'hdeadbeef.
- Reset mid-clear: store 64'h55 to word 10 in RUN, assert reset, then assert reset again 7 cycles into CLEAR -> busy stays high 16 full cycles after final release. Word 10 reads 0 via core and via host.
